// File: rtl/sw_entry_pkg.sv
// Shared types and default timing constants for the push-button operand entry block.
package sw_entry_pkg;

    localparam int DEFAULT_WIDTH             = 5;
    localparam int DEFAULT_DEBOUNCE_CYCLES   = 270000;    // 10 ms at 27 MHz
    localparam int DEFAULT_LONG_PRESS_CYCLES = 13500000;  // 0.5 s at 27 MHz

    // sw2 gesture tracker: idle editing, button held, long press already committed
    typedef enum logic [1:0] {
        EDIT      = 2'd0,
        HOLD      = 2'd1,
        LONG_WAIT = 2'd2
    } entry_state_e;

endpackage

// File: rtl/sw_debounce.sv
// One active-low button: 2-FF synchroniser, stability counter, and one-cycle
// press/release pulses on the debounced level edges.
module sw_debounce
    import sw_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles where the synced input disagrees with the accepted level;
    // the level flips on the cycle that completes DEBOUNCE_CYCLES disagreeing samples.
    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            level_d   = sync2_q;
            press_d   = ~sync2_q;
            release_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Synchroniser and debounce state; everything idles at "released".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            level_q   <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= raw_n_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/sw_operand_entry.sv
// Two-button operand editor: sw1 increments the selected field, a short sw2 press
// toggles the field, a long sw2 press commits (x, y) to the downstream consumer.
//
// Output handshake: out_x/out_y are meaningful and held constant while out_valid is 1;
// the pair is consumed on a rising clk edge where out_valid and out_ready are both 1,
// and out_valid only ever drops on such an edge (or on reset).
module sw_operand_entry
    import sw_entry_pkg::*;
#(
    parameter int WIDTH             = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw1,
    input  logic             sw2,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] live_x,
    output logic [WIDTH-1:0] live_y,
    output logic             sel
);

    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic sw1_press, sw2_press, sw2_release;
    logic unused_sw1_level, unused_sw1_release, unused_sw2_level;

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1_db (
        .clk       (clk),
        .rst       (rst),
        .raw_n_i   (sw1),
        .level_o   (unused_sw1_level),
        .press_o   (sw1_press),
        .release_o (unused_sw1_release)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw2_db (
        .clk       (clk),
        .rst       (rst),
        .raw_n_i   (sw2),
        .level_o   (unused_sw2_level),
        .press_o   (sw2_press),
        .release_o (sw2_release)
    );

    entry_state_e      state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              sel_q;
    logic              commit_req;

    // A release on the same cycle the hold limit is reached counts as a short press.
    assign commit_req = (state_q == HOLD) && !sw2_release && (hold_cnt_q == HOLD_LAST);

    // sw2 gesture FSM: classifies each hold as short (toggle field) or long (commit).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EDIT;
            hold_cnt_q <= '0;
            sel_q      <= 1'b0;
        end else begin
            case (state_q)
                EDIT: begin
                    if (sw2_press) begin
                        state_q    <= HOLD;
                        hold_cnt_q <= '0;
                    end
                end
                HOLD: begin
                    if (sw2_release) begin
                        sel_q   <= ~sel_q;
                        state_q <= EDIT;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q <= LONG_WAIT;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                LONG_WAIT: begin
                    if (sw2_release) state_q <= EDIT;
                end
                default: state_q <= EDIT;
            endcase
        end
    end

    logic [WIDTH-1:0] live_x_q, live_x_d, live_y_q, live_y_d;
    logic [WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d;
    logic             out_valid_q, out_valid_d;

    // Operand edits and commit capture; the commit samples the pre-increment live values
    // and is ignored while a pair is still pending (even if it is consumed this cycle).
    always_comb begin
        live_x_d    = live_x_q;
        live_y_d    = live_y_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        if (sw1_press) begin
            if (sel_q) live_y_d = live_y_q + WIDTH'(1);
            else       live_x_d = live_x_q + WIDTH'(1);
        end
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (commit_req && !out_valid_q) begin
            out_x_d     = live_x_q;
            out_y_d     = live_y_q;
            out_valid_d = 1'b1;
        end
    end

    // Operand and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_x_q    <= '0;
            live_y_q    <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            live_x_q    <= live_x_d;
            live_y_q    <= live_y_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign live_x    = live_x_q;
    assign live_y    = live_y_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_valid = out_valid_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_sw_operand_entry.sv
// Bench for sw_operand_entry with short debounce/long-press timings.
module tb_sw_operand_entry;

  localparam int W    = 5;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw1 = 1'b1;
  logic sw2 = 1'b1;
  logic out_ready = 1'b0;
  logic out_valid, sel;
  logic [W-1:0] out_x, out_y, live_x, live_y;

  always #5 clk = ~clk;

  sw_operand_entry #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .clk(clk), .rst(rst), .sw1(sw1), .sw2(sw2), .out_ready(out_ready),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .live_x(live_x), .live_y(live_y), .sel(sel)
  );

  // reference model: operands, field, pending flag, committed pairs
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] mx, my;
  logic msel, mvalid;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_pair;

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    mx = '0; my = '0; msel = 1'b0; mvalid = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; sw1 = 1'b1; sw2 = 1'b1; out_ready = 1'b0;
    cyc(2);
    rst = 1'b0;
    model_reset();
    cyc(2);
  endtask

  task automatic press_sw1(input int lo, input int hi);
    sw1 = 1'b0; cyc(lo);
    sw1 = 1'b1; cyc(hi);
    if (msel) my = my + 1'b1;
    else      mx = mx + 1'b1;
  endtask

  // Holds below LONG cycles are short presses, well above are long ones.
  task automatic hold_sw2(input int n);
    sw2 = 1'b0; cyc(n);
    sw2 = 1'b1; cyc(10);
    if (n < LONG) msel = ~msel;
    else if (!mvalid) begin
      exp_q.push_back({mx, my});
      mvalid = 1'b1;
    end
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1; cyc(1);
    out_ready = 1'b0; cyc(1);
    mvalid = 1'b0;
  endtask

  // test scenarios
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({live_x, live_y, out_x, out_y, out_valid, sel} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", {live_x, live_y, out_x, out_y, out_valid, sel});
    end
  endtask

  task automatic test_single_press();
    sw1 = 1'b0;
    cyc(6);
    n_cmp++;
    if (live_x !== 5'd0) begin n_err++; $display("FAIL press_early: got %0d expected 0", live_x); end
    cyc(1);
    n_cmp++;
    if (live_x !== 5'd1) begin n_err++; $display("FAIL press_latency: got %0d expected 1", live_x); end
    cyc(3);
    sw1 = 1'b1;
    cyc(10);
    mx = mx + 1'b1;
    n_cmp++;
    if ({live_y, sel} !== {my, msel}) begin
      n_err++; $display("FAIL press_other_field: got %h expected %h", {live_y, sel}, {my, msel});
    end
    sw1 = 1'b0; cyc(3);
    sw1 = 1'b1; cyc(12);
    n_cmp++;
    if (live_x !== mx) begin n_err++; $display("FAIL glitch_ignored: got %0d expected %0d", live_x, mx); end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (33) press_sw1($urandom_range(6, 8), $urandom_range(8, 10));
    n_cmp++;
    if (live_x !== mx) begin n_err++; $display("FAIL wrap_x: got %0d expected %0d", live_x, mx); end
  endtask

  task automatic test_short_press();
    hold_sw2(8);
    n_cmp++;
    if (sel !== msel) begin n_err++; $display("FAIL short_sel: got %0b expected %0b", sel, msel); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL short_no_commit: got %0b expected 0", out_valid); end
    press_sw1(6, 8);
    press_sw1(7, 9);
    n_cmp++;
    if (live_y !== my) begin n_err++; $display("FAIL edit_y: got %0d expected %0d", live_y, my); end
  endtask

  task automatic test_commit();
    repeat (8) press_sw1(6, 8);
    hold_sw2(8);
    repeat (4) press_sw1(6, 8);
    hold_sw2(30);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL commit_valid: got %0b expected 1", out_valid); end
    n_cmp++;
    if ({out_x, out_y} !== exp_q[0]) begin
      n_err++; $display("FAIL commit_pair: got %h expected %h", {out_x, out_y}, exp_q[0]);
    end
    n_cmp++;
    if ({sel, live_x, live_y} !== {msel, mx, my}) begin
      n_err++; $display("FAIL commit_live: got %h expected %h", {sel, live_x, live_y}, {msel, mx, my});
    end
    exp_pair = exp_q.pop_front();
    pulse_ready();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL handshake_clear: got %0b expected 0", out_valid); end
  endtask

  task automatic test_pending_drop();
    hold_sw2(30);
    press_sw1(6, 8);
    press_sw1(6, 8);
    hold_sw2(30);
    n_cmp++;
    if ({out_valid, out_x, out_y} !== {1'b1, exp_q[0]}) begin
      n_err++; $display("FAIL drop_pending: got %h expected %h", {out_valid, out_x, out_y}, {1'b1, exp_q[0]});
    end
    n_cmp++;
    if (live_x !== mx) begin n_err++; $display("FAIL drop_live_x: got %0d expected %0d", live_x, mx); end
  endtask

  task automatic test_simultaneous();
    // sw1 press lands in the same cycle as the sw2 short-press release
    sw2 = 1'b0; cyc(8);
    sw1 = 1'b0; sw2 = 1'b1; cyc(8);
    sw1 = 1'b1; cyc(10);
    if (msel) my = my + 1'b1; else mx = mx + 1'b1;
    msel = ~msel;
    n_cmp++;
    if ({sel, live_x, live_y} !== {msel, mx, my}) begin
      n_err++; $display("FAIL simul_toggle: got %h expected %h", {sel, live_x, live_y}, {msel, mx, my});
    end
    exp_pair = exp_q.pop_front();
    n_cmp++;
    if ({out_x, out_y} !== exp_pair) begin
      n_err++; $display("FAIL simul_drain: got %h expected %h", {out_x, out_y}, exp_pair);
    end
    pulse_ready();
    // sw1 press lands in the same cycle as the long-press commit
    sw2 = 1'b0; cyc(20);
    sw1 = 1'b0; cyc(8);
    sw1 = 1'b1; cyc(6);
    sw2 = 1'b1; cyc(10);
    exp_q.push_back({mx, my});
    mvalid = 1'b1;
    if (msel) my = my + 1'b1; else mx = mx + 1'b1;
    n_cmp++;
    if ({out_valid, out_x, out_y} !== {1'b1, exp_q[0]}) begin
      n_err++; $display("FAIL simul_commit: got %h expected %h", {out_valid, out_x, out_y}, {1'b1, exp_q[0]});
    end
    n_cmp++;
    if ({sel, live_x, live_y} !== {msel, mx, my}) begin
      n_err++; $display("FAIL simul_commit_live: got %h expected %h", {sel, live_x, live_y}, {msel, mx, my});
    end
  endtask

  task automatic test_reset_mid_hold();
    sw2 = 1'b0; cyc(12);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({live_x, live_y, out_x, out_y, out_valid, sel} !== '0) begin
      n_err++; $display("FAIL reset_async: got %h expected 0", {live_x, live_y, out_x, out_y, out_valid, sel});
    end
    cyc(2);
    rst = 1'b0;
    model_reset();
    cyc(1);
    sw2 = 1'b1;
    cyc(20);
    n_cmp++;
    if ({live_x, live_y, out_x, out_y, out_valid, sel} !== '0) begin
      n_err++; $display("FAIL reset_no_event: got %h expected 0", {live_x, live_y, out_x, out_y, out_valid, sel});
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: press_sw1($urandom_range(6, 10), $urandom_range(8, 12));
        1: hold_sw2($urandom_range(6, 12));
        2: hold_sw2($urandom_range(25, 35));
        default: begin
          if (mvalid) begin
            exp_pair = exp_q.pop_front();
            n_cmp++;
            if ({out_x, out_y} !== exp_pair) begin
              n_err++; $display("FAIL rnd_pair[%0d]: got %h expected %h", i, {out_x, out_y}, exp_pair);
            end
          end
          pulse_ready();
        end
      endcase
      n_cmp++;
      if ({sel, live_x, live_y} !== {msel, mx, my}) begin
        n_err++; $display("FAIL rnd_live[%0d]: got %h expected %h", i, {sel, live_x, live_y}, {msel, mx, my});
      end
      n_cmp++;
      if (out_valid !== mvalid) begin
        n_err++; $display("FAIL rnd_valid[%0d]: got %0b expected %0b", i, out_valid, mvalid);
      end
    end
  endtask

  // sequence and final report
  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_wrap();
    test_short_press();
    test_commit();
    test_pending_drop();
    test_simultaneous();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sw_operand_entry.md
Name: sw_operand_entry

Overview:
- Input-side counterpart to the board-LED result display: turns the two active-low Tang Nano 9K push buttons into a pair of 5-bit operands (x, y).
- Synchronises and debounces both buttons, edits the operands with short/long presses, and hands a committed (x, y) pair downstream over a valid/ready handshake.
- The downstream consumer is the abs-difference/LED stage.
- Live operand and field-select outputs let the LEDs show the value being edited.

Parameters:
- WIDTH, 5, operand width in bits; values wrap modulo 2^WIDTH.
- DEBOUNCE_CYCLES, 270000, consecutive stable cycles required to accept a level change (10 ms at 27 MHz); must be >= 2.
- LONG_PRESS_CYCLES, 13500000, sw2 hold length that counts as a long press (0.5 s at 27 MHz); must be greater than DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- sw1  input  1  raw button, active-low (0 = pressed), asynchronous to clk.
- sw2  input  1  raw button, active-low, asynchronous to clk.
- out_ready  input  1  downstream accepts the committed pair.
- out_valid  output  1  committed pair available.
- out_x  output  WIDTH  committed x, stable while out_valid.
- out_y  output  WIDTH  committed y, stable while out_valid.
- live_x  output  WIDTH  x currently being edited.
- live_y  output  WIDTH  y currently being edited.
- sel  output  1  field under edit: 0 = x, 1 = y.

Behaviour:
- Reset (async assert, release sync to clk):
  - live_x = live_y = 0; out_x = out_y = 0; out_valid = 0; sel = 0; FSM = EDIT.
  - Synchroniser and debounced levels = 1 (released). All counters = 0.
- Per button:
  - 2-FF synchroniser.
  - Debounce counter: cleared whenever the synced level equals the debounced level; otherwise increments. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Press = one-cycle pulse on debounced 1->0. Release = one-cycle pulse on debounced 0->1.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Latency: raw edge to press pulse is 2 + DEBOUNCE_CYCLES cycles; the field register updates on the following edge.
- sw1 press:
  - Increments the field selected by sel; WIDTH-bit wrap, 31 -> 0.
  - Acts in every FSM state, including while sw2 is held.
- sw2 FSM:
  - EDIT: sw2 press -> HOLD, hold counter cleared.
  - HOLD: hold counter increments each cycle.
    - Release before the counter reaches LONG_PRESS_CYCLES -> toggle sel, return to EDIT.
    - Counter reaches LONG_PRESS_CYCLES -> commit request, go to LONG_WAIT.
  - LONG_WAIT: release -> EDIT, sel unchanged.
- Commit:
  - If out_valid = 0: capture out_x <= live_x and out_y <= live_y, assert out_valid on the next edge. Live values are unchanged.
  - If out_valid = 1: the request is dropped; the pending pair is not overwritten.
- Handshake:
  - out_valid clears on the edge where out_valid and out_ready are both 1.
  - out_valid never deasserts without out_ready.
  - out_x and out_y do not change while out_valid = 1.
- Simultaneous events:
  - sw1 press in the same cycle as an sw2 short-press release: the increment uses the pre-toggle sel.
  - A commit and an sw1 increment in the same cycle: capture the pre-increment live value.
  - A commit and a handshake completing in the same cycle: the request is dropped, since out_valid = 1 in that cycle.
- Reset mid-hold or mid-handshake returns every output to its reset value immediately; no event is generated by the reset itself.

Decomposition:
- Package sw_entry_pkg:
  - State enum with values EDIT, HOLD, LONG_WAIT.
  - Default WIDTH, DEBOUNCE_CYCLES and LONG_PRESS_CYCLES constants.
- Sub-module sw_debounce:
  - Parameter DEBOUNCE_CYCLES; ports clk, rst, raw_n, level, press, release.
  - Contains the synchroniser, the debounce counter and edge detection.
  - Instantiated twice.
- Top level holds the FSM, hold counter, operand registers and handshake.

Test Plan (DEBOUNCE_CYCLES = 4, LONG_PRESS_CYCLES = 20):
- Reset, then one clean sw1 press held 10 cycles -> live_x goes 0 -> 1 exactly 7 edges after sw1 falls; live_y = 0; sel = 0. A further 3-cycle low glitch produces no change.
- 33 sw1 presses with sel = 0 -> live_x = 1 (wrap through 31 -> 0).
- sw2 held 8 cycles then released -> sel 0 -> 1, out_valid stays 0. Next two sw1 presses -> live_y = 2.
- With live_x = 5, live_y = 10: hold sw2 30 cycles, out_ready = 0 -> out_valid = 1, out_x = 5, out_y = 10. After release, sel is unchanged. Drive out_ready = 1 for one cycle -> out_valid = 0.
- With out_valid pending and out_ready = 0: edit to live_x = 7 and issue another long press -> out_x stays 5 and out_valid stays 1.
- Assert rst while in HOLD with out_valid = 1 -> all outputs 0 and sel = 0 immediately. Release sw2 after rst deasserts -> sel unchanged.
